fft8_out_streamer: RTL

// Downstream stage of the 8-point FFT core. Captures the core's parallel complex

---
 rtl/fft8_out_streamer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fft8_out_streamer.sv
// Output stage of the 8-point FFT: captures a parallel result frame on the rising
// edge of fft_done into a ping-pong buffer pair and streams it one bin per beat.
module fft8_out_streamer #(
    parameter int N       = 8,
    parameter int W       = 16,
    parameter bit BIT_REV = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fft_done,
    input  logic [N*W-1:0]       in_real,
    input  logic [N*W-1:0]       in_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_real,
    output logic [W-1:0]         out_imag,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] KMAX = IW'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state, nxt_state;
    logic          done_d;
    logic [1:0]    fill, fill_next;
    logic          wr_ptr, rd_ptr, nxt_ptr;
    logic [IW-1:0] k, nxt_k, nxt_idx;
    logic          cap, cap_ok, frame_done, load;

    logic [W-1:0]  mem_real [2][N];
    logic [W-1:0]  mem_imag [2][N];

    function automatic logic [IW-1:0] bin_order(input logic [IW-1:0] kk);
        logic [IW-1:0] r;
        r = kk;
        if (BIT_REV) begin
            for (int i = 0; i < IW; i++) r[i] = kk[IW-1-i];
        end
        return r;
    endfunction

    // A full pair may still take a frame if the one draining finishes this cycle.
    assign cap        = fft_done & ~done_d;
    assign frame_done = out_valid & out_ready & out_last;
    assign cap_ok     = cap & ((fill != 2'd2) | frame_done);
    assign fill_next  = fill + {1'b0, cap_ok} - {1'b0, frame_done};
    assign busy       = (fill != 2'd0);

    always_comb begin
        nxt_state = state;
        nxt_k     = k;
        nxt_ptr   = rd_ptr;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (fill != 2'd0) begin
                    nxt_state = STREAM;
                    nxt_k     = '0;
                    load      = 1'b1;
                end
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    if (k != KMAX) begin
                        nxt_k = k + 1'b1;
                        load  = 1'b1;
                    end else begin
                        nxt_k   = '0;
                        nxt_ptr = ~rd_ptr;
                        if (fill == 2'd2) load = 1'b1;
                        else              nxt_state = IDLE;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
        nxt_idx = bin_order(nxt_k);
    end

    always_ff @(posedge clk) begin
        if (cap_ok) begin
            for (int i = 0; i < N; i++) begin
                mem_real[wr_ptr][i] <= in_real[i*W +: W];
                mem_imag[wr_ptr][i] <= in_imag[i*W +: W];
            end
        end
    end

    // Output beat registers are loaded with the next bin whenever the beat advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            done_d    <= 1'b0;
            fill      <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            k         <= '0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            done_d <= fft_done;
            fill   <= fill_next;
            if (cap_ok)          wr_ptr  <= ~wr_ptr;
            if (cap && !cap_ok)  overrun <= 1'b1;
            state  <= nxt_state;
            k      <= nxt_k;
            rd_ptr <= nxt_ptr;
            if (load) begin
                out_valid <= 1'b1;
                out_index <= nxt_idx;
                out_last  <= (nxt_k == KMAX);
                out_real  <= mem_real[nxt_ptr][nxt_idx];
                out_imag  <= mem_imag[nxt_ptr][nxt_idx];
            end else if (nxt_state == IDLE) begin
                out_valid <= 1'b0;
                out_index <= '0;
                out_last  <= 1'b0;
                out_real  <= '0;
                out_imag  <= '0;
            end
        end
    end
endmodule
